// File: rtl/bgr_pkg.sv
// Shared definitions for the bandgap-array scan sequencer: state encoding,
// array geometry and chan_mask bit positions.
package bgr_pkg;

  localparam int NUM_BGR = 32;
  localparam int SEL_W   = 5;

  localparam int MASK_VBGR = 0;
  localparam int MASK_VA   = 1;
  localparam int MASK_VB   = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PORST   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_DEC_ON  = 3'd3,
    ST_DWELL   = 3'd4,
    ST_SW_OFF  = 3'd5,
    ST_DEC_OFF = 3'd6,
    ST_FIN     = 3'd7
  } bgr_state_e;

  function automatic logic [NUM_BGR-1:0] onehot_sel(input logic [SEL_W-1:0] idx);
    logic [NUM_BGR-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/bgr_dwell_timer.sv
// Loadable down-counter shared by the PORST, SETTLE and DWELL phases.
// o_expire is high during the last cycle of a loaded interval.
module bgr_dwell_timer #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_len_fixed;

  // A zero length still occupies one cycle of the phase.
  assign w_len_fixed = (i_len == '0) ? CNT_W'(1) : i_len;
  assign o_expire    = (r_cnt == CNT_W'(1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= w_len_fixed;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/bgr_scan_ctrl.sv
// Scan sequencer for the 32-macro bandgap array: porst pulse, settle, then
// break-before-make routing of the selected macro onto the Vbgr/Va/Vb muxes.
module bgr_scan_ctrl
  import bgr_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               start,
  input  logic               stop,
  input  logic               sweep,
  input  logic [SEL_W-1:0]   first_idx,
  input  logic [SEL_W-1:0]   last_idx,
  input  logic [2:0]         chan_mask,
  input  logic [CNT_W-1:0]   porst_len,
  input  logic [CNT_W-1:0]   settle_len,
  input  logic [CNT_W-1:0]   dwell_len,
  output logic [NUM_BGR-1:0] porst,
  output logic [SEL_W-1:0]   s_vbgr,
  output logic [SEL_W-1:0]   s_va,
  output logic [SEL_W-1:0]   s_vb,
  output logic               decoder_en_vbgr,
  output logic               decoder_en_va,
  output logic               decoder_en_vb,
  output logic               switch_en_vbgr,
  output logic               switch_en_va,
  output logic               switch_en_vb,
  output logic               busy,
  output logic               ch_valid,
  output logic [SEL_W-1:0]   cur_idx,
  output logic               done,
  output logic               aborted,
  output logic [2:0]         o_dbg_state
);

  bgr_state_e         r_state;
  logic [SEL_W-1:0]   r_idx;
  logic               r_sweep;
  logic [SEL_W-1:0]   r_last;
  logic [2:0]         r_mask;
  logic [CNT_W-1:0]   r_plen;
  logic [CNT_W-1:0]   r_slen;
  logic [CNT_W-1:0]   r_dlen;
  logic               r_aborted;

  logic [NUM_BGR-1:0] r_porst;
  logic [SEL_W-1:0]   r_sel;
  logic [2:0]         r_dec;
  logic [2:0]         r_sw;
  logic               r_busy;
  logic               r_ch_valid;
  logic [SEL_W-1:0]   r_cur_idx;
  logic               r_done;

  bgr_state_e         w_next_state;
  logic [SEL_W-1:0]   w_next_idx;
  logic               w_load;
  logic [CNT_W-1:0]   w_len;
  logic               w_accept;
  logic               w_stop_run;
  logic               w_expire;

  bgr_dwell_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .i_clk    (wb_clk_i),
    .i_rst    (wb_rst_i),
    .i_load   (w_load),
    .i_len    (w_len),
    .o_expire (w_expire)
  );

  // A stop seen anywhere between PORST and DEC_OFF aborts the run.
  assign w_stop_run = stop && (r_state inside {ST_PORST, ST_SETTLE, ST_DEC_ON,
                                               ST_DWELL, ST_SW_OFF, ST_DEC_OFF});

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_load       = 1'b0;
    w_len        = r_plen;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          w_accept     = 1'b1;
          w_next_state = ST_PORST;
          w_next_idx   = first_idx;
          w_load       = 1'b1;
          w_len        = porst_len;
        end
      end
      ST_PORST: begin
        if (stop) begin
          w_next_state = ST_DEC_OFF;
        end else if (w_expire) begin
          w_next_state = ST_SETTLE;
          w_load       = 1'b1;
          w_len        = r_slen;
        end
      end
      ST_SETTLE: begin
        if (stop) begin
          w_next_state = ST_DEC_OFF;
        end else if (w_expire) begin
          w_next_state = ST_DEC_ON;
        end
      end
      ST_DEC_ON: begin
        if (stop) begin
          w_next_state = ST_DEC_OFF;
        end else begin
          w_next_state = ST_DWELL;
          w_load       = 1'b1;
          w_len        = r_dlen;
        end
      end
      ST_DWELL: begin
        if (stop || w_expire) begin
          w_next_state = ST_SW_OFF;
        end
      end
      ST_SW_OFF: begin
        w_next_state = ST_DEC_OFF;
      end
      ST_DEC_OFF: begin
        if (stop || r_aborted || !r_sweep || (r_idx == r_last)) begin
          w_next_state = ST_FIN;
        end else begin
          w_next_state = ST_PORST;
          w_next_idx   = r_idx + SEL_W'(1);
          w_load       = 1'b1;
          w_len        = r_plen;
        end
      end
      ST_FIN: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_sweep <= 1'b0;
      r_last  <= '0;
      r_mask  <= '0;
      r_plen  <= '0;
      r_slen  <= '0;
      r_dlen  <= '0;
    end else if (w_accept) begin
      r_sweep <= sweep;
      r_last  <= last_idx;
      r_mask  <= chan_mask;
      r_plen  <= porst_len;
      r_slen  <= settle_len;
      r_dlen  <= dwell_len;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_aborted <= 1'b0;
    end else if (w_accept) begin
      r_aborted <= 1'b0;
    end else if (w_stop_run) begin
      r_aborted <= 1'b1;
    end
  end

  // Outputs are decoded from the next state so they are flops aligned with r_state.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_porst    <= '0;
      r_sel      <= '0;
      r_dec      <= '0;
      r_sw       <= '0;
      r_busy     <= 1'b0;
      r_ch_valid <= 1'b0;
      r_cur_idx  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_idx      <= w_next_idx;
      r_porst    <= (w_next_state == ST_PORST) ? onehot_sel(w_next_idx) : '0;
      r_sel      <= (w_next_state != ST_IDLE) ? w_next_idx : '0;
      r_dec      <= (w_next_state inside {ST_DEC_ON, ST_DWELL, ST_SW_OFF}) ? r_mask : 3'b000;
      r_sw       <= (w_next_state == ST_DWELL) ? r_mask : 3'b000;
      r_busy     <= (w_next_state != ST_IDLE);
      r_ch_valid <= (w_next_state == ST_DWELL);
      r_cur_idx  <= (w_next_state != ST_IDLE) ? w_next_idx : '0;
      r_done     <= (w_next_state == ST_FIN);
    end
  end

  assign porst           = r_porst;
  assign s_vbgr          = r_sel;
  assign s_va            = r_sel;
  assign s_vb            = r_sel;
  assign decoder_en_vbgr = r_dec[MASK_VBGR];
  assign decoder_en_va   = r_dec[MASK_VA];
  assign decoder_en_vb   = r_dec[MASK_VB];
  assign switch_en_vbgr  = r_sw[MASK_VBGR];
  assign switch_en_va    = r_sw[MASK_VA];
  assign switch_en_vb    = r_sw[MASK_VB];
  assign busy            = r_busy;
  assign ch_valid        = r_ch_valid;
  assign cur_idx         = r_cur_idx;
  assign done            = r_done;
  assign aborted         = r_aborted;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_bgr_scan_ctrl.sv
// Bench for bgr_scan_ctrl: a phase-level reference trace per run, compared
// cycle by cycle, plus a break-before-make monitor over the whole run.
module tb_bgr_scan_ctrl;
  import bgr_pkg::*;

  localparam int CNT_W = 16;
  localparam logic [2:0] P_IDLE = 3'd0, P_POR = 3'd1, P_SET = 3'd2, P_DON = 3'd3,
                         P_DW = 3'd4, P_SWO = 3'd5, P_DOF = 3'd6, P_FIN = 3'd7;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             start = 1'b0, stop = 1'b0, sweep = 1'b0;
  logic [4:0]       first_idx = '0, last_idx = '0;
  logic [2:0]       chan_mask = '0;
  logic [CNT_W-1:0] porst_len = '0, settle_len = '0, dwell_len = '0;
  logic [31:0]      porst;
  logic [4:0]       s_vbgr, s_va, s_vb, cur_idx;
  logic             decoder_en_vbgr, decoder_en_va, decoder_en_vb;
  logic             switch_en_vbgr, switch_en_va, switch_en_vb;
  logic             busy, ch_valid, done, aborted;
  logic [2:0]       o_dbg_state;

  bgr_scan_ctrl #(.CNT_W(CNT_W)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .stop(stop), .sweep(sweep),
    .first_idx(first_idx), .last_idx(last_idx), .chan_mask(chan_mask),
    .porst_len(porst_len), .settle_len(settle_len), .dwell_len(dwell_len),
    .porst(porst), .s_vbgr(s_vbgr), .s_va(s_va), .s_vb(s_vb),
    .decoder_en_vbgr(decoder_en_vbgr), .decoder_en_va(decoder_en_va),
    .decoder_en_vb(decoder_en_vb), .switch_en_vbgr(switch_en_vbgr),
    .switch_en_va(switch_en_va), .switch_en_vb(switch_en_vb),
    .busy(busy), .ch_valid(ch_valid), .cur_idx(cur_idx), .done(done),
    .aborted(aborted), .o_dbg_state(o_dbg_state)
  );

  int n_checks = 0;
  int n_err    = 0;
  int bbm_viol = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // break-before-make monitor
  logic       bbm_en = 1'b0, have_prev = 1'b0;
  logic [14:0] prev_sel;
  logic [2:0]  prev_dec;
  always @(negedge clk) begin
    if (!bbm_en) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev) begin
        if ({s_vb, s_va, s_vbgr} != prev_sel &&
            ({decoder_en_vb, decoder_en_va, decoder_en_vbgr, switch_en_vb, switch_en_va,
              switch_en_vbgr} != 6'd0 || prev_dec != 3'd0))
          bbm_viol++;
        if (({switch_en_vb, switch_en_va, switch_en_vbgr} & ~prev_dec) != 3'd0)
          bbm_viol++;
      end
      prev_sel  = {s_vb, s_va, s_vbgr};
      prev_dec  = {decoder_en_vb, decoder_en_va, decoder_en_vbgr};
      have_prev = 1'b1;
    end
  end

  function automatic logic [40:0] act_out();
    return {porst, decoder_en_vb, decoder_en_va, decoder_en_vbgr,
            switch_en_vb, switch_en_va, switch_en_vbgr, busy, ch_valid, done};
  endfunction

  // Expected output vector for one cycle spent in phase e[7:5] on channel e[4:0].
  function automatic logic [40:0] exp_out(input logic [7:0] e, input logic [2:0] m);
    logic [2:0]  ph;
    logic [31:0] p;
    logic [2:0]  dec, sw;
    ph  = e[7:5];
    p   = (ph == P_POR) ? (32'h1 << e[4:0]) : 32'h0;
    dec = (ph == P_DON || ph == P_DW || ph == P_SWO) ? m : 3'd0;
    sw  = (ph == P_DW) ? m : 3'd0;
    return {p, dec, sw, ph != P_IDLE, ph == P_DW, ph == P_FIN};
  endfunction

  // Reference trace: one entry per cycle after start is sampled.
  task automatic build(input logic [4:0] f, input logic [4:0] l, input logic sw,
                       input int pl, input int sl, input int dl);
    logic [4:0] idx;
    int p, s, d;
    p = (pl == 0) ? 1 : pl;
    s = (sl == 0) ? 1 : sl;
    d = (dl == 0) ? 1 : dl;
    exp_q.delete();
    idx = f;
    while (1) begin
      repeat (p) exp_q.push_back({P_POR, idx});
      repeat (s) exp_q.push_back({P_SET, idx});
      exp_q.push_back({P_DON, idx});
      repeat (d) exp_q.push_back({P_DW, idx});
      exp_q.push_back({P_SWO, idx});
      exp_q.push_back({P_DOF, idx});
      if (!sw || idx == l) break;
      idx = idx + 5'd1;
    end
    exp_q.push_back({P_FIN, idx});
    exp_q.push_back({P_IDLE, 5'd0});
  endtask

  // stop_at: -1 none, -2 random, else trace index whose cycle sees stop high.
  task automatic run_case(input logic [4:0] f, input logic [4:0] l, input logic sw,
                          input logic [2:0] m, input int pl, input int sl, input int dl,
                          input int stop_at_in);
    int stop_at;
    logic [7:0] e;
    build(f, l, sw, pl, sl, dl);
    stop_at = stop_at_in;
    if (stop_at == -2) stop_at = $urandom_range(0, exp_q.size() - 3);
    if (stop_at >= 0) begin
      e = exp_q[stop_at];
      while (exp_q.size() > stop_at + 1) void'(exp_q.pop_back());
      case (e[7:5])
        P_POR, P_SET, P_DON: exp_q.push_back({P_DOF, e[4:0]});
        P_DW: begin
          exp_q.push_back({P_SWO, e[4:0]});
          exp_q.push_back({P_DOF, e[4:0]});
        end
        P_SWO: exp_q.push_back({P_DOF, e[4:0]});
        default: ;
      endcase
      exp_q.push_back({P_FIN, e[4:0]});
      exp_q.push_back({P_IDLE, 5'd0});
    end
    first_idx = f; last_idx = l; sweep = sw; chan_mask = m;
    porst_len = CNT_W'(pl); settle_len = CNT_W'(sl); dwell_len = CNT_W'(dl);
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      start = 1'b0;
      first_idx = 5'($urandom); last_idx = 5'($urandom); sweep = 1'($urandom);
      chan_mask = 3'($urandom); porst_len = CNT_W'($urandom_range(0, 9));
      settle_len = CNT_W'($urandom_range(0, 9)); dwell_len = CNT_W'($urandom_range(0, 9));
      stop = (i == stop_at);
      e = exp_q[i];
      check("outs", act_out(), exp_out(e, m));
      if (e[7:5] >= P_POR && e[7:5] <= P_DOF) check("cur_idx", cur_idx, e[4:0]);
      if (e[7:5] >= P_DON && e[7:5] <= P_DOF) check("sel", {s_vb, s_va, s_vbgr}, {3{e[4:0]}});
      if (e[7:5] == P_IDLE) check("idle_sel", {s_vb, s_va, s_vbgr, cur_idx}, 0);
      check("aborted", aborted, (stop_at >= 0) && (i > stop_at));
    end
    stop = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outs", {act_out(), s_vb, s_va, s_vbgr, cur_idx, aborted}, 0);
    rst = 1'b0;
    @(negedge clk);
    bbm_en = 1'b1;

    run_case(5'd5, 5'd5, 1'b0, 3'd7, 3, 4, 8, -1);
    run_case(5'd30, 5'd1, 1'b1, 3'd7, 2, 3, 4, -1);
    // stop mid-DWELL of the second channel of a 4-channel sweep
    run_case(5'd10, 5'd13, 1'b1, 3'd7, 2, 3, 6, 14 + 2 + 3 + 1 + 2);
    run_case(5'd3, 5'd5, 1'b1, 3'd2, 0, 0, 0, -1);
    run_case(5'd20, 5'd22, 1'b1, 3'd0, 1, 2, 2, -1);
    for (int k = 0; k < 12; k++) begin
      logic [4:0] f;
      f = 5'($urandom_range(0, 31));
      run_case(f, f + 5'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
               3'($urandom_range(0, 7)), $urandom_range(0, 4), $urandom_range(0, 4),
               $urandom_range(0, 4), ($urandom_range(0, 2) == 0) ? -2 : -1);
    end

    // start together with stop in IDLE is ignored
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("start_stop_busy", busy, 0);
    @(negedge clk);
    check("start_stop_busy2", {busy, porst}, 0);

    // asynchronous reset while in DWELL
    first_idx = 5'd7; sweep = 1'b0; chan_mask = 3'd7;
    porst_len = 16'd2; settle_len = 16'd2; dwell_len = 16'd10;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 60 && !ch_valid; k++) @(negedge clk);
    check("rst_reach_dwell", ch_valid, 1);
    bbm_en = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_outs", {act_out(), s_vb, s_va, s_vbgr, cur_idx, aborted}, 0);
    check("rst_state", o_dbg_state, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bbm_en = 1'b1;
    run_case(5'd7, 5'd9, 1'b1, 3'd5, 2, 1, 3, -1);

    check("bbm", bbm_viol, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/bgr_scan_ctrl.md
# bgr_scan_ctrl

Digital sequencer that sits directly upstream of the 32-macro bandgap array and its three 32:1 analog output muxes (Vbgr, Va, Vb). It drives each macro's start-up pulse, waits for settling, then routes the selected macro to the output pins. The decoder and switch enables are sequenced break-before-make. It runs one channel or a wrapping sweep over a channel range. Configuration comes from user-project registers; the outputs drive the array's `porst`, select, decoder-enable and switch-enable pins one-to-one.

## Interface
- `CNT_W`, default 16: width of the porst, settle and dwell length inputs and of the internal timer.
- `wb_clk_i  in  1`: clock.
- `wb_rst_i  in  1`: asynchronous, active-high reset.
- `start  in  1`: one-cycle pulse; accepted only in IDLE.
- `stop  in  1`: abort request; level or pulse, sampled every cycle.
- `sweep  in  1`: 0 = single channel `first_idx`; 1 = sweep `first_idx`..`last_idx`.
- `first_idx  in  5`, `last_idx  in  5`: channel range.
- `chan_mask  in  3`: bit0 = Vbgr, bit1 = Va, bit2 = Vb; selects which muxes participate.
- `porst_len  in  CNT_W`, `settle_len  in  CNT_W`, `dwell_len  in  CNT_W`: cycle counts; a value of 0 is treated as 1.
- `porst  out  32`: one-hot start-up pulse to the macros.
- `s_vbgr  out  5`, `s_va  out  5`, `s_vb  out  5`: mux selects.
- `decoder_en_vbgr  out  1`, `decoder_en_va  out  1`, `decoder_en_vb  out  1`.
- `switch_en_vbgr  out  1`, `switch_en_va  out  1`, `switch_en_vb  out  1`.
- `busy  out  1`: high in every state other than IDLE.
- `ch_valid  out  1`: high while the current channel is routed (DWELL).
- `cur_idx  out  5`: channel currently being processed.
- `done  out  1`: one-cycle pulse at the end of a run.
- `aborted  out  1`: sticky flag; set by `stop`, cleared by the next accepted `start`.

## Operation
- Configuration inputs are latched on an accepted `start`. Changes to them mid-run are ignored.
- States: IDLE, PORST, SETTLE, DEC_ON, DWELL, SW_OFF, DEC_OFF, FIN.
- IDLE: all outputs are 0. `start` latches the configuration, sets `cur_idx = first_idx` and moves to PORST.
- PORST: `porst[cur_idx] = 1` for `porst_len` cycles; all other `porst` bits are 0. Then SETTLE.
- SETTLE: wait `settle_len` cycles, then DEC_ON.
- DEC_ON:
  - Selects = `cur_idx`.
  - `decoder_en_x = chan_mask[x]`.
  - Holds for 1 cycle, then DWELL.
- DWELL: `switch_en_x = chan_mask[x]`, `ch_valid = 1`, for `dwell_len` cycles. Then SW_OFF.
- SW_OFF: switches 0; decoder enables stay on; 1 cycle. Then DEC_OFF.
- DEC_OFF: decoder enables 0; 1 cycle. Then:
  - If `sweep = 1` and `cur_idx != last_idx`: `cur_idx` increments modulo 32 (31 wraps to 0) and the FSM goes to PORST.
  - Otherwise: FIN.
- FIN: `done = 1` for 1 cycle, then IDLE.
- Selects hold their value from DEC_ON through DEC_OFF. They change only while both the decoder enable and the switch enable are 0.
- Invariant: `switch_en_x` is never 1 unless `decoder_en_x` has been 1 for at least one prior cycle.
- `stop` handling, by current state:
  - PORST, SETTLE or DEC_ON: go directly to DEC_OFF with switches 0.
  - DWELL: go to SW_OFF.
  - SW_OFF or DEC_OFF: continue as normal.
  - In every case the FSM then goes to FIN, sets `aborted`, and skips any remaining channels.
- `stop` and `start` in the same IDLE cycle: `start` is ignored.
- `chan_mask = 0`: the full sequence still runs (porst and timing), but no enables are asserted.

## Timing
- Reset value of every output is 0, including `aborted`.
- All outputs are registered; there is no combinational path from input to output.
- First `porst` pulse rises 1 cycle after `start` is sampled.
- Per-channel length is `porst_len + settle_len + 1 + dwell_len + 2` cycles (zero lengths counted as 1).
- `done` follows DEC_OFF of the last channel by 1 cycle.
- Reset mid-run: all enables and `porst` drop asynchronously to 0.

## Structure
- Shared package `bgr_pkg`:
  - State enum.
  - `NUM_BGR = 32`, `SEL_W = 5`.
  - Chan-mask bit positions.
- One sub-module, `bgr_dwell_timer`: loadable down-counter of width `CNT_W` with load, zero-as-one handling and an `expire` pulse. It is shared by PORST, SETTLE and DWELL.

## Test plan
- Single channel: `first_idx = 5`, `porst_len = 3`, `settle_len = 4`, `dwell_len = 8`, `chan_mask = 7`, then `start`.
  - `porst = 0x20` for 3 cycles.
  - Decoder enables rise at cycle 8, switches at 9 for 8 cycles.
  - `done` at cycle 19.
- Wrapping sweep: `first_idx = 30`, `last_idx = 1`, `sweep = 1`.
  - `cur_idx` visits 30, 31, 0, 1, each channel lasting its full per-channel length.
  - One `done` pulse after the last channel.
- Break-before-make checker over the whole sweep: selects never change while any decoder or switch enable is 1; `switch_en` never rises without `decoder_en` high in the previous cycle.
- `stop` during DWELL of channel 2 of a 4-channel sweep:
  - Switches drop next cycle, decoder enables the cycle after.
  - Then `done`, with `aborted = 1`; channels 3–4 are never pulsed.
- Zero lengths and mask: all lengths 0 with `chan_mask = 2`.
  - Each phase lasts 1 cycle.
  - Only `decoder_en_va` and `switch_en_va` toggle.
- Async reset asserted in DWELL: all outputs are 0 within the same cycle, the FSM is in IDLE, and a new `start` runs normally.
